// File: rtl/sipo_deser_param_if.sv
// Serial-slice in / assembled-word out handshake bundle
// for the parameterised SIPO deserialiser.
interface sipo_deser_param_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 1,
    parameter int DEPTH  = 4
);
    logic [LANES-1:0]         s_data_i;
    logic                     s_valid_i;
    logic                     s_sof_i;
    logic                     s_ready_o;
    logic                     flush_i;
    logic [DATA_W-1:0]        m_data_o;
    logic                     m_valid_o;
    logic                     m_ready_i;
    logic [$clog2(DEPTH):0]   level_o;
    logic                     align_err_o;

    modport master (
        output s_data_i, s_valid_i, s_sof_i,
        output flush_i, m_ready_i,
        input  s_ready_o, m_data_o, m_valid_o,
        input  level_o, align_err_o
    );

    modport slave (
        input  s_data_i, s_valid_i, s_sof_i,
        input  flush_i, m_ready_i,
        output s_ready_o, m_data_o, m_valid_o,
        output level_o, align_err_o
    );
endinterface

// File: rtl/sipo_deser_param.sv
// Serial-in parallel-out deserialiser: LANES bits per beat,
// sof-framed words, first-word-fall-through output FIFO.
module sipo_deser_param #(
    parameter int DATA_W    = 8,
    parameter int LANES     = 1,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    sipo_deser_param_if.slave bus
);
    localparam int BEATS = DATA_W / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    logic [0:0]        state_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] part_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              err_q;
    logic              live_q;

    logic              s_ready;
    logic              acc;
    logic              take;
    logic              last;
    logic              push;
    logic              pop;
    logic              err;
    logic [CW-1:0]     idx;
    logic [DATA_W-1:0] word;

    always_comb begin
        s_ready = live_q
                && (level_q < LW'(DEPTH))
                && !bus.flush_i;
        acc  = bus.s_valid_i && s_ready;
        take = acc && (bus.s_sof_i
                || state_q == ST_COLLECT);
        idx  = bus.s_sof_i ? '0 : cnt_q;
        last = take && (idx == CW'(BEATS - 1));
        push = last;
        pop  = (level_q != '0) && bus.m_ready_i;
        err  = acc && bus.s_sof_i
            && (state_q == ST_COLLECT);
    end

    // A sof slice always restarts from an empty word.
    always_comb begin
        word = bus.s_sof_i ? '0 : part_q;
        for (int b = 0; b < BEATS; b++) begin
            if (CW'(b) == idx) begin
                word[((MSB_FIRST != 0)
                      ? (BEATS - 1 - b) : b) * LANES
                     +: LANES] = bus.s_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            part_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (bus.flush_i) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                part_q   <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
                err_q    <= 1'b0;
            end else begin
                err_q <= err;
                if (take) begin
                    if (last) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        part_q  <= '0;
                    end else begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= idx + CW'(1);
                        part_q  <= word;
                    end
                end
                if (push)
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                unique case ({push, pop})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !bus.flush_i)
            mem[wr_ptr_q] <= word;
    end

    assign bus.s_ready_o   = s_ready;
    assign bus.m_valid_o   = (level_q != '0);
    assign bus.m_data_o    = (level_q != '0)
                           ? mem[rd_ptr_q] : '0;
    assign bus.level_o     = level_q;
    assign bus.align_err_o = err_q;
endmodule
